// File: rtl/spi_slave_regfile.sv
// ---------------------------------------------------------------------------
// spi_slave_regfile
//
// SPI mode-0 slave endpoint holding a 2^ADDR_W x DATA_W register file. The
// SCLK, CS_n and MOSI inputs are oversampled on PCLK through synchronizers.
// Write frames (cmd=1, addr, data; MSB first) commit a register write.
// Read frames (cmd=0, addr) shift the register back on MISO, LSB first.
//
// Ports:
//   PCLK        system clock, rising edge
//   resetn      asynchronous reset, active high
//   SCLK        SPI clock from the master (idle low)
//   CS_n        chip select, active low
//   MOSI        serial data in, MSB first
//   MISO        serial read data, LSB first, 0 while MISO_oe is low
//   MISO_oe     MISO pad output enable
//   wr_valid    one-PCLK pulse per committed register write
//   wr_addr     address of the committed write
//   wr_data     data of the committed write
//   busy        frame in progress (FSM not idle)
//   frame_err   one-PCLK pulse when CS_n rises before the frame completes
// ---------------------------------------------------------------------------
module spi_slave_regfile #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              PCLK,
    input  logic              resetn,
    input  logic              SCLK,
    input  logic              CS_n,
    input  logic              MOSI,
    output logic              MISO,
    output logic              MISO_oe,
    output logic              wr_valid,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              frame_err
);

    localparam int MAX_W = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
    localparam int CNT_W = $clog2(MAX_W + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_WDATA,
        S_RDATA,
        S_DONE
    } state_t;

    state_t state, state_next;

    logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
    logic                   sclk_prev, cs_prev;
    logic                   sclk_s, cs_s, mosi_s;
    logic                   sclk_rise, sclk_fall, cs_fall;

    logic [CNT_W-1:0]       bit_cnt;
    logic                   cmd_bit;
    logic [ADDR_W-1:0]      addr_sr;
    logic [ADDR_W-1:0]      addr_full;
    logic [DATA_W-2:0]      data_sr;
    logic [DATA_W-1:0]      data_full;
    logic [DATA_W-1:0]      rd_sr;
    logic                   addr_last, wdata_last, rdata_last;
    logic                   abort, commit;

    logic [DATA_W-1:0]      mem [2**ADDR_W];

    // Synchronizers plus one history flop per line for edge detection.
    // CS_n idles high so its chain resets to 1 to avoid a false frame start.
    always_ff @(posedge PCLK or posedge resetn) begin
        if (resetn) begin
            sclk_sync <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
            sclk_prev <= 1'b0;
            cs_prev   <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], CS_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
            sclk_prev <= sclk_s;
            cs_prev   <= cs_s;
        end
    end

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev;
    assign sclk_fall = ~sclk_s & sclk_prev;
    assign cs_fall   = ~cs_s & cs_prev;

    // Field values including the bit arriving on this rise, so the last
    // bit of a field can be acted on in the same PCLK it is sampled.
    assign addr_full = {addr_sr[ADDR_W-2:0], mosi_s};
    assign data_full = {data_sr, mosi_s};

    assign addr_last  = sclk_rise && (bit_cnt == CNT_W'(ADDR_W - 1));
    assign wdata_last = sclk_rise && (bit_cnt == CNT_W'(DATA_W - 1));
    // The extra fall after the last presented bit ends the read phase.
    assign rdata_last = sclk_fall && (bit_cnt == CNT_W'(DATA_W));

    // CS_n high wins over any SCLK event seen in the same PCLK.
    assign abort  = cs_s && (state inside {S_CMD, S_ADDR, S_WDATA, S_RDATA});
    assign commit = (state == S_WDATA) && !cs_s && wdata_last;

    assign busy = (state != S_IDLE);

    always_ff @(posedge PCLK or posedge resetn) begin
        if (resetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (cs_fall) state_next = S_CMD;
            S_CMD: begin
                if (cs_s)           state_next = S_IDLE;
                else if (sclk_rise) state_next = S_ADDR;
            end
            S_ADDR: begin
                if (cs_s)           state_next = S_IDLE;
                else if (addr_last) state_next = cmd_bit ? S_WDATA : S_RDATA;
            end
            S_WDATA: begin
                if (cs_s)            state_next = S_IDLE;
                else if (wdata_last) state_next = S_DONE;
            end
            S_RDATA: begin
                if (cs_s)            state_next = S_IDLE;
                else if (rdata_last) state_next = S_DONE;
            end
            S_DONE:  if (cs_s) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Datapath: field shift registers, bit counter, write strobe and the
    // MISO shifter. The counter restarts on every state change.
    always_ff @(posedge PCLK or posedge resetn) begin
        if (resetn) begin
            bit_cnt   <= '0;
            cmd_bit   <= 1'b0;
            addr_sr   <= '0;
            data_sr   <= '0;
            rd_sr     <= '0;
            MISO      <= 1'b0;
            MISO_oe   <= 1'b0;
            wr_valid  <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            frame_err <= 1'b0;
        end else begin
            wr_valid  <= 1'b0;
            frame_err <= abort;

            if (state_next != state) begin
                bit_cnt <= '0;
            end else if (((state == S_ADDR) || (state == S_WDATA)) && sclk_rise) begin
                bit_cnt <= bit_cnt + CNT_W'(1);
            end else if ((state == S_RDATA) && sclk_fall) begin
                bit_cnt <= bit_cnt + CNT_W'(1);
            end

            if (abort) begin
                MISO    <= 1'b0;
                MISO_oe <= 1'b0;
            end else begin
                case (state)
                    S_CMD: begin
                        if (sclk_rise) cmd_bit <= mosi_s;
                    end
                    S_ADDR: begin
                        if (sclk_rise) addr_sr <= addr_full;
                        if (addr_last && !cmd_bit) begin
                            rd_sr   <= mem[addr_full];
                            MISO    <= 1'b0;
                            MISO_oe <= 1'b1;
                        end
                    end
                    S_WDATA: begin
                        if (sclk_rise) data_sr <= data_full[DATA_W-2:0];
                        if (commit) begin
                            wr_valid <= 1'b1;
                            wr_addr  <= addr_sr;
                            wr_data  <= data_full;
                        end
                    end
                    S_RDATA: begin
                        if (rdata_last) begin
                            MISO    <= 1'b0;
                            MISO_oe <= 1'b0;
                        end else if (sclk_fall) begin
                            MISO  <= rd_sr[0];
                            rd_sr <= {1'b0, rd_sr[DATA_W-1:1]};
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Register storage is deliberately left out of reset.
    always_ff @(posedge PCLK) begin
        if (commit) begin
            mem[addr_sr] <= data_full;
        end
    end

endmodule

// File: tb/tb_spi_slave_regfile.sv
// ---------------------------------------------------------------------------
// tb_spi_slave_regfile
//
// Self-checking bench for spi_slave_regfile. Acts as an SPI mode-0 master
// with SCLK = PCLK/8, runs a table of directed frames, hand-written abort,
// mid-read reset and back-to-back sequences, then random frames checked
// against an array model of the register file.
// ---------------------------------------------------------------------------
module tb_spi_slave_regfile;

    localparam int HALF = 4;
    localparam int GAP  = 6;

    logic       PCLK;
    logic       resetn;
    logic       SCLK;
    logic       CS_n;
    logic       MOSI;
    logic       MISO;
    logic       MISO_oe;
    logic       wr_valid;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       busy;
    logic       frame_err;

    int total;
    int bad;
    int wr_pulses;
    int err_pulses;
    logic [15:0] wr_q[$];

    logic [7:0] model_mem [256];
    logic [7:0] written_q[$];

    typedef struct {
        bit         is_write;
        logic [7:0] addr;
        logic [7:0] data;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[7];

    spi_slave_regfile dut (
        .PCLK      (PCLK),
        .resetn    (resetn),
        .SCLK      (SCLK),
        .CS_n      (CS_n),
        .MOSI      (MOSI),
        .MISO      (MISO),
        .MISO_oe   (MISO_oe),
        .wr_valid  (wr_valid),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy),
        .frame_err (frame_err)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    // Observe single-cycle strobes away from the active edge.
    always @(negedge PCLK) begin
        if (wr_valid) begin
            wr_pulses++;
            wr_q.push_back({wr_addr, wr_data});
        end
        if (frame_err) err_pulses++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge PCLK);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic sclk_bit(input logic b);
        MOSI = b;
        tick(HALF);
        SCLK = 1'b1;
        tick(HALF);
        SCLK = 1'b0;
    endtask

    // Write frame; nbits < 17 cuts the frame short to provoke an abort.
    task automatic do_write(input logic [7:0] addr, input logic [7:0] data,
                            input int nbits, input int gap);
        logic [16:0] frame;
        frame = {1'b1, addr, data};
        CS_n = 1'b0;
        for (int i = 0; i < nbits; i++) sclk_bit(frame[16 - i]);
        tick(HALF);
        CS_n = 1'b1;
        tick(gap);
    endtask

    // Read frame; stop_at >= 0 returns with CS_n still low right after
    // sampling that data bit.
    task automatic do_read(input logic [7:0] addr, input int stop_at,
                           output logic [7:0] val, output int oe_cnt,
                           output logic oe_after, output logic busy_done);
        val       = '0;
        oe_cnt    = 0;
        oe_after  = 1'b1;
        busy_done = 1'b0;
        CS_n = 1'b0;
        sclk_bit(1'b0);
        for (int i = 7; i >= 0; i--) sclk_bit(addr[i]);
        for (int k = 0; k < 8; k++) begin
            tick(HALF);
            if (MISO_oe) oe_cnt++;
            val[k] = MISO;
            if (k == stop_at) return;
            SCLK = 1'b1;
            tick(HALF);
            SCLK = 1'b0;
        end
        tick(HALF + 1);
        oe_after  = MISO_oe;
        busy_done = busy;
        CS_n = 1'b1;
        tick(GAP);
    endtask

    task automatic write_and_check(input logic [7:0] addr, input logic [7:0] data);
        logic [15:0] got;
        do_write(addr, data, 17, GAP);
        checkOutput("wr_pulse_count", wr_q.size(), 1);
        got = (wr_q.size() != 0) ? wr_q.pop_front() : 16'hxxxx;
        checkOutput("wr_addr", got[15:8], addr);
        checkOutput("wr_data", got[7:0], data);
        checkOutput("busy_after_write", busy, 1'b0);
        wr_q.delete();
        model_mem[addr] = data;
        written_q.push_back(addr);
    endtask

    task automatic read_and_check(input logic [7:0] addr, input logic [7:0] exp);
        logic [7:0] val;
        int         oe_cnt;
        logic       oe_after;
        logic       busy_done;
        do_read(addr, -1, val, oe_cnt, oe_after, busy_done);
        checkOutput("read_data", val, exp);
        checkOutput("miso_oe_bits", oe_cnt, 8);
        checkOutput("miso_oe_after", oe_after, 1'b0);
        checkOutput("busy_in_done", busy_done, 1'b1);
        checkOutput("busy_after_read", busy, 1'b0);
    endtask

    task automatic applyStimulus(input vec_t v);
        if (v.is_write) write_and_check(v.addr, v.data);
        else            read_and_check(v.addr, v.exp);
    endtask

    initial begin
        logic [7:0]  val;
        int          oe_cnt;
        logic        oe_after;
        logic        busy_done;
        logic [15:0] got;
        int          pulses0;
        int          errs0;

        total      = 0;
        bad        = 0;
        wr_pulses  = 0;
        err_pulses = 0;

        vecs[0] = '{1'b1, 8'hAA, 8'h55, 8'h00};
        vecs[1] = '{1'b0, 8'hAA, 8'h00, 8'h55};
        vecs[2] = '{1'b1, 8'hFF, 8'h12, 8'h00};
        vecs[3] = '{1'b1, 8'h00, 8'h34, 8'h00};
        vecs[4] = '{1'b1, 8'hFF, 8'h9C, 8'h00};
        vecs[5] = '{1'b0, 8'hFF, 8'h00, 8'h9C};
        vecs[6] = '{1'b0, 8'h00, 8'h00, 8'h34};

        SCLK   = 1'b0;
        CS_n   = 1'b1;
        MOSI   = 1'b0;
        resetn = 1'b1;
        tick(4);
        checkOutput("reset_MISO", MISO, 1'b0);
        checkOutput("reset_MISO_oe", MISO_oe, 1'b0);
        checkOutput("reset_wr_valid", wr_valid, 1'b0);
        checkOutput("reset_wr_addr", wr_addr, 8'h00);
        checkOutput("reset_wr_data", wr_data, 8'h00);
        checkOutput("reset_busy", busy, 1'b0);
        checkOutput("reset_frame_err", frame_err, 1'b0);
        resetn = 1'b0;
        tick(GAP);

        for (int i = 0; i < 7; i++) applyStimulus(vecs[i]);

        // Aborted write after 12 rises: error pulse, no commit, old data kept.
        pulses0 = wr_pulses;
        errs0   = err_pulses;
        do_write(8'hAA, 8'h00, 12, GAP);
        checkOutput("abort_frame_err", err_pulses - errs0, 1);
        checkOutput("abort_no_write", wr_pulses - pulses0, 0);
        checkOutput("abort_busy", busy, 1'b0);
        read_and_check(8'hAA, 8'h55);

        // Reset while bit 3 of a read is on MISO (0x5A has bit 3 set).
        write_and_check(8'h3C, 8'h5A);
        do_read(8'h3C, 3, val, oe_cnt, oe_after, busy_done);
        checkOutput("pre_reset_MISO_oe", MISO_oe, 1'b1);
        checkOutput("pre_reset_MISO", MISO, 1'b1);
        checkOutput("pre_reset_bits", val[3:0], 4'hA);
        resetn = 1'b1;
        #1;
        checkOutput("mid_reset_MISO_oe", MISO_oe, 1'b0);
        checkOutput("mid_reset_MISO", MISO, 1'b0);
        checkOutput("mid_reset_busy", busy, 1'b0);
        tick(2);
        SCLK   = 1'b0;
        CS_n   = 1'b1;
        resetn = 1'b0;
        tick(GAP);
        read_and_check(8'h3C, 8'h5A);

        // Back-to-back writes with the minimum CS_n high time.
        wr_q.delete();
        pulses0 = wr_pulses;
        do_write(8'h11, 8'hC3, 17, 3);
        do_write(8'h22, 8'h3C, 17, GAP);
        checkOutput("b2b_pulses", wr_pulses - pulses0, 2);
        got = (wr_q.size() != 0) ? wr_q.pop_front() : 16'hxxxx;
        checkOutput("b2b_first", got, 16'h11C3);
        got = (wr_q.size() != 0) ? wr_q.pop_front() : 16'hxxxx;
        checkOutput("b2b_second", got, 16'h223C);
        wr_q.delete();
        model_mem[8'h11] = 8'hC3;
        model_mem[8'h22] = 8'h3C;
        written_q.push_back(8'h11);
        written_q.push_back(8'h22);
        read_and_check(8'h11, 8'hC3);

        // Random traffic against the array model.
        for (int n = 0; n < 24; n++) begin
            logic [7:0] a;
            logic [7:0] d;
            if ($urandom_range(0, 1) == 0) begin
                a = 8'($urandom_range(0, 255));
                d = 8'($urandom);
                write_and_check(a, d);
            end else begin
                a = written_q[$urandom_range(0, written_q.size() - 1)];
                read_and_check(a, model_mem[a]);
            end
        end

        checkOutput("total_frame_err", err_pulses, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
